// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared integer-pipeline definitions: ALU operation codes, base opcodes,
// register-index width and the control bundle carried by the ID/EX register.
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   // ALU operation codes
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SLL  = 4'b0011;
   localparam logic [3:0] ALU_SLT  = 4'b0100;
   localparam logic [3:0] ALU_SLTU = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_XOR  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1010;

   // RV32I base opcodes (inst[6:0])
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // Control fields held alongside the operands in the ID/EX register
   typedef struct packed {
      logic [31:0] inst;
      logic [3:0]  alu_ctrl;
      logic        use_imm;
      logic        reg_write;
   } idex_ctrl_t;

   // Stores take operand 2 from the immediate but still need rs2 as store
   // data, so they depend on rs2 even when use_imm is set.
   function automatic logic is_store(input logic [31:0] inst);
      return inst[6:0] == OPC_STORE;
   endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// -----------------------------------------------------------------------------
// operand_fwd_mux
// Combinational resolve of one source operand against the EX/MEM and MEM/WB
// forwarding buses.
//   idx / stored            : source register index and the value held for it
//   mem_we/is_load/rd/data  : EX/MEM forwarding bus
//   wb_we/rd/data           : MEM/WB forwarding bus
//   res                     : resolved operand value
// -----------------------------------------------------------------------------
module operand_fwd_mux
   import riscv_pkg::*;
#(
   parameter int N      = 32,
   parameter int REG_AW = riscv_pkg::REG_AW
) (
   input  logic [REG_AW-1:0] idx,
   input  logic [N-1:0]      stored,
   input  logic              mem_we,
   input  logic              mem_is_load,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [N-1:0]      mem_data,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [N-1:0]      wb_data,
   output logic [N-1:0]      res
);

   logic idx_zero;
   logic mem_hit;
   logic wb_hit;

   assign idx_zero = (idx == '0);
   // A load in EX/MEM has no data yet; its address result must not be forwarded.
   assign mem_hit  = mem_we && !mem_is_load && (mem_rd == idx);
   assign wb_hit   = wb_we && (wb_rd == idx);

   // Younger producer (EX/MEM) wins over older (MEM/WB).
   always_comb begin
      res = stored;
      if (idx_zero)     res = '0;
      else if (mem_hit) res = mem_data;
      else if (wb_hit)  res = wb_data;
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
// One-entry ID/EX register in front of the ALU. Captures the decoded entry,
// forwards from EX/MEM and MEM/WB, stalls on load-use and hands the resolved
// operands to the ALU under valid/ready.
//   clk, rst             : clock, synchronous active-high reset
//   in_*                 : decode entry + handshake (in_ready is combinational
//                          on out_ready)
//   flush                : drop the held entry and any same-cycle capture
//   mem_fwd_*, wb_fwd_*  : forwarding buses from EX/MEM and MEM/WB
//   out_*                : resolved entry to the ALU + handshake
// -----------------------------------------------------------------------------
module id_ex_operand_stage
   import riscv_pkg::*;
#(
   parameter int N      = 32,
   parameter int REG_AW = riscv_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_inst,
   input  logic [3:0]        in_alu_ctrl,
   input  logic [REG_AW-1:0] in_rs1_idx,
   input  logic [REG_AW-1:0] in_rs2_idx,
   input  logic [N-1:0]      in_rs1_data,
   input  logic [N-1:0]      in_rs2_data,
   input  logic [N-1:0]      in_imm,
   input  logic              in_use_imm,
   input  logic [REG_AW-1:0] in_rd_idx,
   input  logic              in_reg_write,
   input  logic              flush,
   input  logic              mem_fwd_we,
   input  logic              mem_fwd_is_load,
   input  logic [REG_AW-1:0] mem_fwd_rd,
   input  logic [N-1:0]      mem_fwd_data,
   input  logic              wb_fwd_we,
   input  logic [REG_AW-1:0] wb_fwd_rd,
   input  logic [N-1:0]      wb_fwd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N-1:0]      out_rs1,
   output logic [N-1:0]      out_rs2,
   output logic [N-1:0]      out_store_data,
   output logic [3:0]        out_alu_ctrl,
   output logic [31:0]       out_inst,
   output logic [REG_AW-1:0] out_rd_idx,
   output logic              out_reg_write
);

   localparam int NSRC = 2;   // [0] = rs1, [1] = rs2

   logic                             valid_q;
   idex_ctrl_t                       ctrl_q;
   logic [REG_AW-1:0]                rd_q;
   logic [N-1:0]                     imm_q;
   logic [NSRC-1:0][REG_AW-1:0]      src_idx_q;
   logic [NSRC-1:0][N-1:0]           src_data_q;
   logic [NSRC-1:0][N-1:0]           src_res;

   logic need_rs2;
   logic load_pending;
   logic hazard;
   logic fire;
   logic capture;

   // ---------------------------------------------------------------- forwarding
   for (genvar g = 0; g < NSRC; g++) begin : g_src
      operand_fwd_mux #(
         .N      (N),
         .REG_AW (REG_AW)
      ) u_fwd (
         .idx         (src_idx_q[g]),
         .stored      (src_data_q[g]),
         .mem_we      (mem_fwd_we),
         .mem_is_load (mem_fwd_is_load),
         .mem_rd      (mem_fwd_rd),
         .mem_data    (mem_fwd_data),
         .wb_we       (wb_fwd_we),
         .wb_rd       (wb_fwd_rd),
         .wb_data     (wb_fwd_data),
         .res         (src_res[g])
      );
   end

   // ------------------------------------------------------------ hazard / flow
   assign need_rs2     = !ctrl_q.use_imm || is_store(ctrl_q.inst);
   assign load_pending = mem_fwd_we && mem_fwd_is_load && (mem_fwd_rd != '0);
   assign hazard       = valid_q && load_pending &&
                         ((mem_fwd_rd == src_idx_q[0]) ||
                          (need_rs2 && (mem_fwd_rd == src_idx_q[1])));

   assign out_valid = valid_q && !hazard;
   assign fire      = out_valid && out_ready;
   assign in_ready  = !valid_q || (out_ready && !hazard);
   assign capture   = in_valid && in_ready;

   // ----------------------------------------------------------------- register
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         ctrl_q     <= '0;
         rd_q       <= '0;
         imm_q      <= '0;
         src_idx_q  <= '0;
         src_data_q <= '0;
      end else if (flush) begin
         // Redirect: the held entry and any entry offered this cycle are dead.
         valid_q <= 1'b0;
      end else if (capture) begin
         valid_q          <= 1'b1;
         ctrl_q.inst      <= in_inst;
         ctrl_q.alu_ctrl  <= in_alu_ctrl;
         ctrl_q.use_imm   <= in_use_imm;
         ctrl_q.reg_write <= in_reg_write;
         rd_q             <= in_rd_idx;
         imm_q            <= in_imm;
         src_idx_q        <= {in_rs2_idx, in_rs1_idx};
         src_data_q       <= {in_rs2_data, in_rs1_data};
      end else if (fire) begin
         valid_q <= 1'b0;
      end else if (valid_q) begin
         // Holding: fold any forward seen this cycle into the stored operand so
         // it survives the producer retiring past WB before we are released.
         src_data_q <= src_res;
      end
   end

   // ------------------------------------------------------------------ outputs
   assign out_rs1        = src_res[0];
   assign out_rs2        = ctrl_q.use_imm ? imm_q : src_res[1];
   assign out_store_data = src_res[1];
   assign out_alu_ctrl   = ctrl_q.alu_ctrl;
   assign out_inst       = ctrl_q.inst;
   assign out_rd_idx     = rd_q;
   assign out_reg_write  = valid_q && ctrl_q.reg_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;
   import riscv_pkg::*;

   localparam int N  = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready;
   logic [31:0]   in_inst;
   logic [3:0]    in_alu_ctrl;
   logic [AW-1:0] in_rs1_idx, in_rs2_idx, in_rd_idx;
   logic [N-1:0]  in_rs1_data, in_rs2_data, in_imm;
   logic          in_use_imm, in_reg_write, flush;
   logic          mem_fwd_we, mem_fwd_is_load;
   logic [AW-1:0] mem_fwd_rd, wb_fwd_rd;
   logic [N-1:0]  mem_fwd_data, wb_fwd_data;
   logic          wb_fwd_we;
   logic          out_valid, out_ready;
   logic [N-1:0]  out_rs1, out_rs2, out_store_data;
   logic [3:0]    out_alu_ctrl;
   logic [31:0]   out_inst;
   logic [AW-1:0] out_rd_idx;
   logic          out_reg_write;

   id_ex_operand_stage #(.N(N), .REG_AW(AW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .in_alu_ctrl(in_alu_ctrl), .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
      .in_use_imm(in_use_imm), .in_rd_idx(in_rd_idx), .in_reg_write(in_reg_write),
      .flush(flush),
      .mem_fwd_we(mem_fwd_we), .mem_fwd_is_load(mem_fwd_is_load),
      .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
      .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_store_data(out_store_data),
      .out_alu_ctrl(out_alu_ctrl), .out_inst(out_inst),
      .out_rd_idx(out_rd_idx), .out_reg_write(out_reg_write)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------ reference
   typedef struct {
      logic [N-1:0]  rs1, rs2, sd;
      logic [3:0]    alu;
      logic [31:0]   inst;
      logic [AW-1:0] rd;
      logic          rw;
   } xfer_t;

   typedef struct {
      logic [31:0]   inst;
      logic [3:0]    alu;
      logic          ui, rw;
      logic [AW-1:0] rd, i1, i2;
      logic [N-1:0]  d1, d2, imm;
   } ent_t;

   xfer_t exp_q[$];   // transfers the model predicts, in order
   ent_t  held[$];    // the instruction currently sitting in the stage (0 or 1)

   int vectors     = 0;
   int miscompares = 0;
   bit mon_en      = 1'b0;
   bit exp_ov      = 1'b0;
   bit exp_ir      = 1'b1;

   // Value an instruction sees for register idx, given what it already holds:
   // x0 reads zero, newest non-load producer wins, else what it has.
   function automatic logic [N-1:0] see(input logic [AW-1:0] idx, input logic [N-1:0] have);
      if (idx == 0) return '0;
      if (mem_fwd_we && !mem_fwd_is_load && mem_fwd_rd == idx) return mem_fwd_data;
      if (wb_fwd_we && wb_fwd_rd == idx) return wb_fwd_data;
      return have;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply the current inputs to the model for one cycle.
   task automatic eval();
      ent_t  e = '{default: '0};
      xfer_t x;
      bit    occ, waits_load, ov, go, ir;
      logic [N-1:0] r1, r2;
      occ = held.size() != 0;
      if (occ) e = held[0];
      r1 = see(e.i1, e.d1);
      r2 = see(e.i2, e.d2);
      // Waiting on a load whose data is not back yet, for any register it reads.
      waits_load = occ && mem_fwd_we && mem_fwd_is_load && mem_fwd_rd != 0 &&
                   (mem_fwd_rd == e.i1 ||
                    ((!e.ui || e.inst[6:0] == 7'b0100011) && mem_fwd_rd == e.i2));
      ov = occ && !waits_load;
      go = ov && out_ready;
      ir = !occ || (out_ready && !waits_load);
      exp_ov = ov;
      exp_ir = ir;
      if (go) begin
         x.rs1 = r1; x.rs2 = e.ui ? e.imm : r2; x.sd = r2;
         x.alu = e.alu; x.inst = e.inst; x.rd = e.rd; x.rw = e.rw;
         exp_q.push_back(x);
      end
      if (rst || flush) held.delete();
      else if (in_valid && ir) begin
         held.delete();
         held.push_back('{inst: in_inst, alu: in_alu_ctrl, ui: in_use_imm, rw: in_reg_write,
                          rd: in_rd_idx, i1: in_rs1_idx, i2: in_rs2_idx,
                          d1: in_rs1_data, d2: in_rs2_data, imm: in_imm});
      end else if (go) held.delete();
      else if (occ) begin
         e.d1 = r1; e.d2 = r2;
         held[0] = e;
      end
      mon_en = 1'b1;
   endtask

   task automatic fin();
      @(posedge clk); #1;
   endtask
   task automatic cyc();
      eval(); fin();
   endtask
   task automatic look();
      eval(); #3;
   endtask

   task automatic set_in(input logic [AW-1:0] i1, input logic [N-1:0] d1,
                         input logic [AW-1:0] i2, input logic [N-1:0] d2,
                         input logic ui, input logic [N-1:0] imm,
                         input logic [AW-1:0] rd, input logic [3:0] alu,
                         input logic [31:0] inst);
      in_valid = 1'b1; in_rs1_idx = i1; in_rs1_data = d1; in_rs2_idx = i2;
      in_rs2_data = d2; in_use_imm = ui; in_imm = imm; in_rd_idx = rd;
      in_alu_ctrl = alu; in_inst = inst; in_reg_write = 1'b1;
   endtask

   task automatic clr_fwd();
      mem_fwd_we = 0; mem_fwd_is_load = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
      wb_fwd_we = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
   endtask

   // -------------------------------------------------------------- monitor
   always @(negedge clk) begin
      if (mon_en) begin
         chk("out_valid", out_valid, exp_ov);
         chk("in_ready", in_ready, exp_ir);
         if (out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL xfer: unexpected transfer inst=%h (t=%0t)", out_inst, $time);
            end else begin
               xfer_t e;
               e = exp_q.pop_front();
               if (out_rs1 !== e.rs1 || out_rs2 !== e.rs2 || out_store_data !== e.sd ||
                   out_alu_ctrl !== e.alu || out_inst !== e.inst || out_rd_idx !== e.rd ||
                   out_reg_write !== e.rw) begin
                  miscompares++;
                  $display("FAIL xfer: got rs1=%h rs2=%h sd=%h alu=%h inst=%h rd=%0d rw=%b expected rs1=%h rs2=%h sd=%h alu=%h inst=%h rd=%0d rw=%b (t=%0t)",
                           out_rs1, out_rs2, out_store_data, out_alu_ctrl, out_inst, out_rd_idx,
                           out_reg_write, e.rs1, e.rs2, e.sd, e.alu, e.inst, e.rd, e.rw, $time);
               end
            end
         end
      end
   end

   // ------------------------------------------------------------- stimulus
   initial begin
      rst = 1; flush = 0; out_ready = 0; in_valid = 0;
      set_in(0, 0, 0, 0, 0, 0, 0, 4'd0, 32'd0);
      in_valid = 0; in_reg_write = 0;
      clr_fwd();
      fin();

      // 1: reset, then a plain ADD
      repeat (2) begin
         look();
         chk("rst_out_valid", out_valid, 0);
         chk("rst_reg_write", out_reg_write, 0);
         chk("rst_in_ready", in_ready, 1);
         fin();
      end
      rst = 0;
      set_in(1, 5, 2, 7, 0, 0, 3, ALU_ADD, 32'h002081B3);
      cyc();
      in_valid = 0;
      look();
      chk("add_valid", out_valid, 1);
      chk("add_rs1", out_rs1, 5);
      chk("add_rs2", out_rs2, 7);
      chk("add_alu", out_alu_ctrl, 4'b0010);
      chk("add_rw", out_reg_write, 1);
      fin();
      out_ready = 1; cyc(); out_ready = 0;

      // 2: forwarding priority, retention and x0
      set_in(3, 0, 5, 1, 1, 32'h100, 8, ALU_ADD, 32'h10018413);
      cyc();
      in_valid = 0;
      mem_fwd_we = 1; mem_fwd_rd = 3; mem_fwd_data = 32'h10;
      wb_fwd_we = 1;  wb_fwd_rd = 3;  wb_fwd_data = 32'h20;
      look(); chk("fwd_mem_prio", out_rs1, 32'h10); chk("fwd_imm", out_rs2, 32'h100); fin();
      mem_fwd_we = 0;
      look(); chk("fwd_wb", out_rs1, 32'h20); fin();
      wb_fwd_we = 0;
      look(); chk("fwd_retain", out_rs1, 32'h20); fin();
      out_ready = 1; cyc(); out_ready = 0;
      set_in(0, 32'h77, 5, 1, 1, 0, 9, ALU_OR, 32'h00006493);
      cyc();
      in_valid = 0;
      wb_fwd_we = 1; wb_fwd_rd = 0; wb_fwd_data = 9;
      look(); chk("x0_zero", out_rs1, 0); fin();
      clr_fwd(); out_ready = 1; cyc(); out_ready = 0;

      // 3: load-use stall on rs2, released by WB forward
      set_in(6, 1, 4, 2, 0, 0, 10, ALU_SUB, 32'h40430533);
      out_ready = 1;
      cyc();
      set_in(1, 11, 2, 12, 0, 0, 11, ALU_XOR, 32'h0020C5B3);
      mem_fwd_we = 1; mem_fwd_is_load = 1; mem_fwd_rd = 4; mem_fwd_data = 32'hDEAD;
      look(); chk("lu_valid", out_valid, 0); chk("lu_in_ready", in_ready, 0); fin();
      clr_fwd();
      wb_fwd_we = 1; wb_fwd_rd = 4; wb_fwd_data = 32'hAB;
      look(); chk("lu_release", out_valid, 1); chk("lu_rs2", out_rs2, 32'hAB);
      chk("lu_in_ready2", in_ready, 1); fin();
      clr_fwd(); in_valid = 0;
      cyc();
      out_ready = 0;

      // 4: stall three cycles, forward seen only in the first
      set_in(7, 3, 2, 4, 1, 32'h8, 12, ALU_AND, 32'h0083F613);
      cyc();
      in_valid = 0;
      wb_fwd_we = 1; wb_fwd_rd = 7; wb_fwd_data = 32'h55;
      look(); chk("hold_fwd", out_rs1, 32'h55); fin();
      clr_fwd();
      repeat (2) begin look(); chk("hold_keep", out_rs1, 32'h55); fin(); end
      out_ready = 1;
      look(); chk("hold_rel_valid", out_valid, 1); chk("hold_rel_rs1", out_rs1, 32'h55); fin();
      look(); chk("hold_once", out_valid, 0); fin();

      // 5: flush beats capture, then a back-to-back stream
      set_in(1, 1, 2, 2, 0, 0, 13, ALU_ADD, 32'h002086B3);
      flush = 1;
      cyc();
      flush = 0; in_valid = 0;
      look(); chk("flush_drop", out_valid, 0); fin();
      for (int i = 0; i < 12; i++) begin
         set_in(AW'($urandom_range(0, 31)), $urandom, AW'($urandom_range(0, 31)), $urandom,
                1'($urandom_range(0, 1)), $urandom, AW'($urandom_range(0, 31)),
                4'($urandom_range(0, 15)), $urandom);
         cyc();
      end
      in_valid = 0;
      cyc(); cyc();
      chk("stream_drained", exp_q.size(), 0);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] inst;
         inst = $urandom;
         if ($urandom_range(0, 3) == 0) inst[6:0] = 7'b0100011;
         rst = ($urandom_range(0, 299) == 0);
         flush = ($urandom_range(0, 19) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         set_in(AW'($urandom_range(0, 7)), $urandom, AW'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), $urandom, AW'($urandom_range(0, 7)),
                4'($urandom_range(0, 15)), inst);
         in_valid = ($urandom_range(0, 3) != 0);
         in_reg_write = 1'($urandom_range(0, 1));
         mem_fwd_we = 1'($urandom_range(0, 1));
         mem_fwd_is_load = ($urandom_range(0, 2) == 0);
         mem_fwd_rd = AW'($urandom_range(0, 7));
         mem_fwd_data = $urandom;
         wb_fwd_we = 1'($urandom_range(0, 1));
         wb_fwd_rd = AW'($urandom_range(0, 7));
         wb_fwd_data = $urandom;
         cyc();
      end

      rst = 0; flush = 0; in_valid = 0; out_ready = 1;
      clr_fwd();
      repeat (3) cyc();
      chk("sb_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
